// File: rtl/systolic_mac_array.sv
// Output-stationary rows_p x cols_p systolic MAC array: skewed operand injection, in-place
// accumulation and row-wise drain. Define SYSTOLIC_MAC_SIGNED_EN for two's-complement operands.
module systolic_mac_array #(
   parameter int width_p     = 8,
   parameter int acc_width_p = 24,
   parameter int rows_p      = 4,
   parameter int cols_p      = 4,
   parameter int max_k_p     = 16
) (
   input  logic                            clk_i,
   input  logic                            reset_ni,
   input  logic                            en_i,
   input  logic                            flush_i,
   input  logic [$clog2(max_k_p+1)-1:0]    k_i,
   input  logic                            valid_i,
   output logic                            ready_o,
   input  logic [rows_p*width_p-1:0]       a_i,
   input  logic [cols_p*width_p-1:0]       b_i,
   output logic                            valid_o,
   input  logic                            yumi_i,
   output logic [cols_p*acc_width_p-1:0]   data_o,
   output logic [$clog2(rows_p)-1:0]       row_o,
   output logic                            busy_o,
   output logic                            idle_o
);
   // state  | meaning
   // IDLE   | waiting for the first beat of a job; accumulators are zero
   // LOAD   | accepting operand beats 2..k
   // FLUSH  | no new operands; rows_p+cols_p-1 cycles let the skewed wavefront finish
   // DRAIN  | presenting C one row per yumi_i; last row returns to IDLE and clears C

   localparam int kw_lp = $clog2(max_k_p+1);
   localparam int rw_lp = $clog2(rows_p);
   localparam int cw_lp = $clog2(max_k_p + rows_p + cols_p + 1);
   localparam logic [cw_lp-1:0] flush_cnt_lp = cw_lp'(rows_p + cols_p - 2);

   typedef enum logic [1:0] {S_IDLE, S_LOAD, S_FLUSH, S_DRAIN} state_e;

   state_e           state_q, state_d;
   logic [cw_lp-1:0] cnt_q, cnt_d;
   logic [rw_lp-1:0] row_q, row_d;
   logic [kw_lp-1:0] k_eff;
   logic             beat_ok;
   logic             acc_clr;

   logic [width_p-1:0]     a_w   [rows_p][cols_p];
   logic [width_p-1:0]     b_w   [rows_p][cols_p];
   logic [acc_width_p-1:0] acc_w [rows_p][cols_p];

   function automatic logic [acc_width_p-1:0] mac_prod(input logic [width_p-1:0] a,
                                                       input logic [width_p-1:0] b);
      logic [2*width_p-1:0] p;
`ifdef SYSTOLIC_MAC_SIGNED_EN
      p = $signed(a) * $signed(b);
      return acc_width_p'($signed(p));
`else
      p = a * b;
      return acc_width_p'(p);
`endif
   endfunction

   assign ready_o = en_i & ((state_q == S_IDLE) | (state_q == S_LOAD));
   assign beat_ok = ready_o & valid_i;
   assign valid_o = en_i & (state_q == S_DRAIN);
   assign busy_o  = (state_q != S_IDLE);
   assign idle_o  = (state_q == S_IDLE);
   assign row_o   = row_q;

   always_comb begin
      if (k_i == '0)                      k_eff = kw_lp'(1);
      else if (k_i > kw_lp'(max_k_p))     k_eff = kw_lp'(max_k_p);
      else                                k_eff = k_i;
   end

   // cnt_q: beats still to come in LOAD, remaining settle cycles in FLUSH
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      row_d   = row_q;
      acc_clr = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (beat_ok) begin
               if (k_eff == kw_lp'(1)) begin
                  state_d = S_FLUSH;
                  cnt_d   = flush_cnt_lp;
               end else begin
                  state_d = S_LOAD;
                  cnt_d   = cw_lp'(k_eff) - cw_lp'(1);
               end
            end
         end
         S_LOAD: begin
            if (beat_ok) begin
               if (cnt_q == cw_lp'(1)) begin
                  state_d = S_FLUSH;
                  cnt_d   = flush_cnt_lp;
               end else begin
                  cnt_d = cnt_q - cw_lp'(1);
               end
            end
         end
         S_FLUSH: begin
            if (en_i) begin
               if (cnt_q == '0) begin
                  state_d = S_DRAIN;
                  row_d   = '0;
               end else begin
                  cnt_d = cnt_q - cw_lp'(1);
               end
            end
         end
         S_DRAIN: begin
            if (en_i && yumi_i) begin
               if (row_q == rw_lp'(rows_p-1)) begin
                  state_d = S_IDLE;
                  row_d   = '0;
                  acc_clr = 1'b1;
               end else begin
                  row_d = row_q + rw_lp'(1);
               end
            end
         end
         default: state_d = S_IDLE;
      endcase
      if (flush_i) begin
         state_d = S_IDLE;
         cnt_d   = '0;
         row_d   = '0;
         acc_clr = 1'b1;
      end
   end

   always_ff @(posedge clk_i or negedge reset_ni) begin
      if (!reset_ni) begin
         state_q <= S_IDLE;
         cnt_q   <= '0;
         row_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         row_q   <= row_d;
      end
   end

   genvar r, c;

   // Input skew: A row r delayed r cycles, B column c delayed c cycles; idle cycles inject zero
   for (r = 0; r < rows_p; r++) begin : g_askew
      logic [width_p-1:0] a_in;
      assign a_in = beat_ok ? a_i[r*width_p +: width_p] : '0;
      if (r == 0) begin : g_nodly
         assign a_w[r][0] = a_in;
      end else begin : g_dly
         logic [width_p-1:0] dly_q [r];
         always_ff @(posedge clk_i or negedge reset_ni) begin
            if (!reset_ni) begin
               for (int i = 0; i < r; i++) dly_q[i] <= '0;
            end else if (acc_clr) begin
               for (int i = 0; i < r; i++) dly_q[i] <= '0;
            end else if (en_i) begin
               dly_q[0] <= a_in;
               for (int i = 1; i < r; i++) dly_q[i] <= dly_q[i-1];
            end
         end
         assign a_w[r][0] = dly_q[r-1];
      end
   end

   for (c = 0; c < cols_p; c++) begin : g_bskew
      logic [width_p-1:0] b_in;
      assign b_in = beat_ok ? b_i[c*width_p +: width_p] : '0;
      if (c == 0) begin : g_nodly
         assign b_w[0][c] = b_in;
      end else begin : g_dly
         logic [width_p-1:0] dly_q [c];
         always_ff @(posedge clk_i or negedge reset_ni) begin
            if (!reset_ni) begin
               for (int i = 0; i < c; i++) dly_q[i] <= '0;
            end else if (acc_clr) begin
               for (int i = 0; i < c; i++) dly_q[i] <= '0;
            end else if (en_i) begin
               dly_q[0] <= b_in;
               for (int i = 1; i < c; i++) dly_q[i] <= dly_q[i-1];
            end
         end
         assign b_w[0][c] = dly_q[c-1];
      end
   end

   for (r = 0; r < rows_p; r++) begin : g_row
      for (c = 0; c < cols_p; c++) begin : g_col
         logic [acc_width_p-1:0] acc_q;
         always_ff @(posedge clk_i or negedge reset_ni) begin
            if (!reset_ni)   acc_q <= '0;
            else if (acc_clr) acc_q <= '0;
            else if (en_i)    acc_q <= acc_q + mac_prod(a_w[r][c], b_w[r][c]);
         end
         assign acc_w[r][c] = acc_q;

         if (c < cols_p-1) begin : g_fwd_a
            logic [width_p-1:0] a_q;
            always_ff @(posedge clk_i or negedge reset_ni) begin
               if (!reset_ni)    a_q <= '0;
               else if (acc_clr) a_q <= '0;
               else if (en_i)    a_q <= a_w[r][c];
            end
            assign a_w[r][c+1] = a_q;
         end

         if (r < rows_p-1) begin : g_fwd_b
            logic [width_p-1:0] b_q;
            always_ff @(posedge clk_i or negedge reset_ni) begin
               if (!reset_ni)    b_q <= '0;
               else if (acc_clr) b_q <= '0;
               else if (en_i)    b_q <= b_w[r][c];
            end
            assign b_w[r+1][c] = b_q;
         end
      end
   end

   always_comb begin
      data_o = '0;
      if (state_q == S_DRAIN) begin
         for (int i = 0; i < cols_p; i++) data_o[i*acc_width_p +: acc_width_p] = acc_w[row_q][i];
      end
   end

endmodule

// File: tb/tb_systolic_mac_array.sv
// Self-checking bench for systolic_mac_array: directed table, corner-case sequences and
// random jobs compared against a plain matrix-product model.
`timescale 1ns/1ps
module tb_systolic_mac_array;
   localparam int W = 8, ACC = 24, R = 4, C = 4, MAXK = 16;
   localparam int KW = $clog2(MAXK+1);

   logic              clk_i = 1'b0, reset_ni = 1'b0, en_i = 1'b1, flush_i = 1'b0;
   logic              valid_i = 1'b0, yumi_i = 1'b0;
   logic [KW-1:0]     k_i = '0;
   logic [R*W-1:0]    a_i = '0;
   logic [C*W-1:0]    b_i = '0;
   logic              ready_o, valid_o, busy_o, idle_o;
   logic [C*ACC-1:0]  data_o;
   logic [1:0]        row_o;

   int checks = 0, failures = 0, cyc = 0;

   logic [W-1:0]   ja [MAXK][R];
   logic [W-1:0]   jb [MAXK][C];
   logic [ACC-1:0] exp_c [R][C];
   logic [ACC-1:0] got_c [R][C];

   typedef struct {
      int          kin;
      logic [31:0] a;
      logic [31:0] b;
      logic [23:0] c00;
      logic [23:0] c33;
   } vec_t;
   vec_t tbl [5];

   systolic_mac_array #(.width_p(W), .acc_width_p(ACC), .rows_p(R), .cols_p(C), .max_k_p(MAXK)) dut (
      .clk_i(clk_i), .reset_ni(reset_ni), .en_i(en_i), .flush_i(flush_i), .k_i(k_i),
      .valid_i(valid_i), .ready_o(ready_o), .a_i(a_i), .b_i(b_i), .valid_o(valid_o),
      .yumi_i(yumi_i), .data_o(data_o), .row_o(row_o), .busy_o(busy_o), .idle_o(idle_o));

   always #5 clk_i = ~clk_i;
   always @(posedge clk_i) cyc <= cyc + 1;

   task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   function automatic int eff_k(input int kin);
      if (kin == 0) return 1;
      if (kin > MAXK) return MAXK;
      return kin;
   endfunction

   function automatic longint prod(input logic [W-1:0] a, input logic [W-1:0] b);
      longint x, y;
      x = a;
      y = b;
`ifdef SYSTOLIC_MAC_SIGNED_EN
      if (x > 127) x -= 256;
      if (y > 127) y -= 256;
`endif
      return x * y;
   endfunction

   task automatic build_model(input int keff);
      longint s;
      for (int r = 0; r < R; r++)
         for (int c = 0; c < C; c++) begin
            s = 0;
            for (int i = 0; i < keff; i++) s += prod(ja[i][r], jb[i][c]);
            exp_c[r][c] = s[ACC-1:0];
         end
   endtask

   task automatic drive_beat(input int i);
      for (int r = 0; r < R; r++) a_i[r*W +: W] = ja[i][r];
      for (int c = 0; c < C; c++) b_i[c*W +: W] = jb[i][c];
   endtask

   task automatic fill_identity();
      for (int i = 0; i < MAXK; i++) begin
         for (int r = 0; r < R; r++) ja[i][r] = (i == r) ? 8'd1 : 8'd0;
         for (int c = 0; c < C; c++) jb[i][c] = W'(4*i + c + 1);
      end
   endtask

   function automatic logic [C*ACC-1:0] exp_row(input int r);
      logic [C*ACC-1:0] v;
      for (int c = 0; c < C; c++) v[c*ACC +: ACC] = exp_c[r][c];
      return v;
   endfunction

   // Send one job, then take stop_rows rows; bubble: valid every other cycle; ymode: yumi every third cycle
   task automatic run_job(input int kin, input bit bubble, input bit ymode, input int stop_rows);
      int keff, i, guard, t0, taken;
      bit first_seen, hold_prev;
      logic [C*ACC-1:0] prev_data;
      logic [1:0] prev_row;
      keff = eff_k(kin);
      build_model(keff);
      i = 0; guard = 0; t0 = 0;
      while (i < keff && guard < 400) begin
         @(posedge clk_i); #1;
         valid_i = !bubble || (guard % 2 == 0);
         k_i = KW'(kin);
         drive_beat(i);
         #1;
         if (valid_i && ready_o && en_i) begin
            if (i == 0) t0 = cyc;
            i++;
         end
         guard++;
      end
      check("beats_accepted", i, keff);
      taken = 0; guard = 0; first_seen = 0; hold_prev = 0; prev_data = '0; prev_row = '0;
      while (taken < stop_rows && guard < 600) begin
         @(posedge clk_i); #1;
         valid_i = 1'b0;
         yumi_i = 1'b0;
         #1;
         if (valid_o) begin
            if (!first_seen) begin
               first_seen = 1;
               if (!bubble) check("latency", cyc - t0, keff + R + C - 1);
            end
            if (hold_prev) begin
               check("hold_data", data_o, prev_data);
               check("hold_row", row_o, prev_row);
            end
            check("row_idx", row_o, taken);
            check("row_data", data_o, exp_row(taken));
            check("ready_in_drain", ready_o, 0);
            for (int c = 0; c < C; c++) got_c[taken][c] = data_o[c*ACC +: ACC];
            if (!ymode || (guard % 3 == 0)) begin
               yumi_i = 1'b1;
               taken++;
               hold_prev = 0;
            end else begin
               hold_prev = 1;
               prev_data = data_o;
               prev_row = row_o;
            end
         end else begin
            check("ready_in_flush", ready_o, 0);
         end
         guard++;
      end
      check("rows_taken", taken, stop_rows);
      if (stop_rows == R) begin
         @(posedge clk_i); #1;
         yumi_i = 1'b0;
         #1;
         check("idle_after", idle_o, 1);
         check("ready_after", ready_o, 1);
         check("valid_after", valid_o, 0);
      end
   endtask

   task automatic load_outer();
      for (int i = 0; i < MAXK; i++) begin
         for (int r = 0; r < R; r++) ja[i][r] = W'(r + 1);
         for (int c = 0; c < C; c++) jb[i][c] = W'(c + 5);
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      bit seen;
      tbl[0] = '{1,  32'h04030201, 32'h08070605, 24'd5,  24'd32};
      tbl[1] = '{0,  32'h0300000A, 32'h09010107, 24'd70, 24'd27};
`ifdef SYSTOLIC_MAC_SIGNED_EN
      tbl[2] = '{3,  32'hFFFFFFFF, 32'h02020202, 24'hFFFFFA, 24'hFFFFFA};
      tbl[3] = '{2,  32'hFFFFFFFF, 32'hFFFFFFFF, 24'd2, 24'd2};
`else
      tbl[2] = '{3,  32'hFFFFFFFF, 32'h02020202, 24'd1530, 24'd1530};
      tbl[3] = '{2,  32'hFFFFFFFF, 32'hFFFFFFFF, 24'd130050, 24'd130050};
`endif
      tbl[4] = '{20, 32'h01010101, 32'h01010101, 24'd16, 24'd16};

      #1;
      check("rst_ready", ready_o, 1);
      check("rst_valid", valid_o, 0);
      check("rst_data", data_o, 0);
      check("rst_row", row_o, 0);
      check("rst_busy", busy_o, 0);
      check("rst_idle", idle_o, 1);
      repeat (2) @(posedge clk_i);
      #1 reset_ni = 1'b1;

      // identity, back-to-back, latency 11
      fill_identity();
      run_job(4, 0, 0, R);

      for (int t = 0; t < 5; t++) begin
         for (int i = 0; i < MAXK; i++) begin
            for (int r = 0; r < R; r++) ja[i][r] = tbl[t].a[r*8 +: 8];
            for (int c = 0; c < C; c++) jb[i][c] = tbl[t].b[c*8 +: 8];
         end
         run_job(tbl[t].kin, 0, 0, R);
         check("tbl_c00", got_c[0][0], tbl[t].c00);
         check("tbl_c33", got_c[3][3], tbl[t].c33);
      end

      // bubbles and backpressure
      fill_identity();
      run_job(4, 1, 1, R);

      // abort after beat 2 with a simultaneous beat that must be dropped
      fill_identity();
      for (int i = 0; i < 2; i++) begin
         @(posedge clk_i); #1;
         valid_i = 1'b1; k_i = KW'(4); drive_beat(i);
      end
      @(posedge clk_i); #1;
      flush_i = 1'b1; valid_i = 1'b1; drive_beat(2);
      @(posedge clk_i); #1;
      flush_i = 1'b0; valid_i = 1'b0;
      #1;
      check("abort_idle", idle_o, 1);
      check("abort_busy", busy_o, 0);
      seen = 0;
      for (int i = 0; i < 20; i++) begin
         @(posedge clk_i); #2;
         if (valid_o) seen = 1;
      end
      check("abort_no_valid", seen, 0);
      run_job(4, 0, 0, R);

      // en_i freeze during DRAIN, yumi ignored
      load_outer();
      run_job(1, 0, 0, 1);
      @(posedge clk_i); #1;
      en_i = 1'b0; yumi_i = 1'b1;
      #1;
      check("freeze_valid", valid_o, 0);
      check("freeze_ready", ready_o, 0);
      repeat (3) @(posedge clk_i);
      #1;
      check("freeze_row", row_o, 1);
      en_i = 1'b1; yumi_i = 1'b0;
      #1;
      check("thaw_valid", valid_o, 1);
      check("thaw_data", data_o, exp_row(1));
      for (int r = 1; r < R; r++) begin
         #0 yumi_i = 1'b1;
         check("thaw_row", row_o, r);
         @(posedge clk_i); #1;
      end
      yumi_i = 1'b0;
      #1;
      check("thaw_idle", idle_o, 1);

      // reset mid-DRAIN after row 1 taken
      fill_identity();
      run_job(4, 0, 0, 2);
      @(posedge clk_i); #1;
      yumi_i = 1'b0;
      #1;
      check("mid_row", row_o, 2);
      reset_ni = 1'b0;
      #1;
      check("mid_rst_valid", valid_o, 0);
      check("mid_rst_data", data_o, 0);
      check("mid_rst_idle", idle_o, 1);
      repeat (2) @(posedge clk_i);
      #1 reset_ni = 1'b1;
      load_outer();
      run_job(1, 0, 0, R);
      check("post_rst_c33", got_c[3][3], 24'd32);

      // random jobs
      for (int j = 0; j < 8; j++) begin
         for (int i = 0; i < MAXK; i++) begin
            for (int r = 0; r < R; r++) ja[i][r] = W'($urandom);
            for (int c = 0; c < C; c++) jb[i][c] = W'($urandom);
         end
         run_job(int'($urandom_range(0, 20)), 1'($urandom), 1'($urandom), R);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule

// File: doc/systolic_mac_array.md
Name: systolic_mac_array

Overview:
- Parametrised output-stationary systolic MAC array; successor to systolic_array, generalised to rows_p x cols_p PEs with a runtime inner dimension.
- Streams one column of A and one row of B per beat, skews them internally, and accumulates C = A x B in place.
- Drains C one row per beat over a valid/yumi interface.
- Sits between the operand-fetch buffers and the result writeback path.

Parameters:
width_p, 8, operand width (bits)
acc_width_p, 24, accumulator and output element width
rows_p, 4, PE rows (rows of A and C)
cols_p, 4, PE columns (columns of B and C)
max_k_p, 16, maximum inner dimension per job

Ports:
clk_i  in  1  clock, rising edge
reset_ni  in  1  asynchronous, active-low reset
en_i  in  1  global advance enable; low freezes all state
flush_i  in  1  synchronous abort of current job
k_i  in  $clog2(max_k_p+1)  inner dimension; sampled on the first beat of a job
valid_i  in  1  operand beat valid
ready_o  out  1  operand beat accepted when valid_i & ready_o & en_i
a_i  in  rows_p*width_p  A column; element r at bits [r*width_p +: width_p]
b_i  in  cols_p*width_p  B row; element c at bits [c*width_p +: width_p]
valid_o  out  1  result row valid
yumi_i  in  1  consumer takes the row; legal only while valid_o=1
data_o  out  cols_p*acc_width_p  row of C; element c at [c*acc_width_p +: acc_width_p]
row_o  out  $clog2(rows_p)  index of the row on data_o
busy_o  out  1  state != IDLE
idle_o  out  1  state == IDLE

Behaviour:
- Reset (reset_ni=0, async): state IDLE, all accumulators, skew registers and counters 0. ready_o=1, valid_o=0, data_o=0, row_o=0, busy_o=0, idle_o=1.
- States: IDLE, LOAD, FLUSH, DRAIN.
- IDLE:
  - ready_o=1.
  - On an accepted beat, latch k=(k_i==0 ? 1 : min(k_i, max_k_p)) and count this beat as beat 1.
  - If k=1, go to FLUSH; else go to LOAD.
- LOAD:
  - ready_o=1; count accepted beats.
  - When beat k is accepted, go to FLUSH.
  - Cycles with en_i=1 and valid_i=0 inject zero operands, so bubbles are harmless.
- Skew and PE array:
  - A element r is delayed r cycles and B element c is delayed c cycles before entering the array.
  - Operands pass right/down one PE per en_i cycle.
  - PE(r,c) computes acc <= acc + a*b.
  - Product is 2*width_p bits, zero-extended to acc_width_p. The sum wraps modulo 2^acc_width_p; no saturation.
- FLUSH:
  - ready_o=0.
  - Counts exactly rows_p+cols_p-1 en_i cycles, then goes to DRAIN.
- DRAIN:
  - valid_o=1, row_o starts at 0, data_o = accumulators of row row_o.
  - On yumi_i, increment row_o.
  - yumi_i on row rows_p-1: clear all accumulators, row_o=0, go to IDLE; ready_o=1 in the following cycle.
  - data_o and row_o are held stable while valid_o=1 and yumi_i=0.
- Latency: with back-to-back beats and yumi_i held high, first valid_o occurs k+rows_p+cols_p-1 cycles after the first accepted beat.
- en_i=0:
  - No state, counter, skew or accumulator changes.
  - ready_o=0 and valid_o=0; yumi_i ignored.
- flush_i=1 (any state, regardless of en_i): the next cycle is IDLE with accumulators, skew registers and counters cleared.
  - Takes priority over a simultaneous beat acceptance or yumi_i; neither takes effect.
- yumi_i while valid_o=0: ignored. valid_i outside IDLE/LOAD: ignored (ready_o=0).
- Reset asserted mid-job: immediate return to reset values; no partial result is ever presented.

Optional Feature:
- SYSTOLIC_MAC_SIGNED_EN defined: operands are two's complement, and products are sign-extended to acc_width_p before accumulation.
- Undefined: operands are unsigned, and products are zero-extended.

Test Plan:
- Identity: A=I4, B rows {1,2,3,4},{5,6,7,8},{9,10,11,12},{13,14,15,16}, k_i=4, beats back-to-back, yumi_i=1 -> rows 0..3 equal B. First valid_o exactly 4+7=11 cycles after the first beat.
- Outer product: k_i=1, a=[1,2,3,4], b=[5,6,7,8] -> row r = (r+1)*[5,6,7,8]. For example, row 3 = [20,24,28,32].
- Backpressure and bubbles: identity job with valid_i toggling every other cycle, yumi_i asserted every third cycle -> same C. data_o and row_o are stable during yumi_i=0. ready_o=0 throughout FLUSH/DRAIN.
- Abort: flush_i pulsed after beat 2 of a k=4 job -> next cycle idle_o=1, valid_o never asserted. A following identity job returns exact B with no residue.
- Reset mid-DRAIN after row 1 taken: reset_ni low 2 cycles -> valid_o=0, data_o=0, idle_o=1 immediately. A following outer-product job is correct.
- Signedness: a all 0xFF, b all 0x02, k_i=3:
  - SYSTOLIC_MAC_SIGNED_EN defined -> every C element 0xFFFFFA (-6).
  - Undefined -> every C element 1530 (0x0005FA).
